// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, MODE bit positions and the
// accumulator width rule used by the multiply-by-constant unit.
package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int MODE_SIGNED = 0;
  localparam int MODE_SAT    = 1;

  // One extra accumulator bit per processed FACTOR bit keeps every partial sum exact.
  function automatic int acc_width(input int width, input int factor_width);
    return width + factor_width;
  endfunction

endpackage

// File: rtl/sat_overflow_chk.sv
// Range check of the exact product against the result width, producing the
// wrapped or saturated result and the overflow flag.
module sat_overflow_chk
  import alu_pkg::*;
#(
  parameter int ACC_W     = 9,
  parameter int OUT_WIDTH = 9
) (
  input  logic [ACC_W-1:0]     product_i,
  input  logic                 signed_i,
  input  logic                 saturate_i,
  output logic [OUT_WIDTH-1:0] f_next_o,
  output logic                 of_next_o
);

  generate
    if (OUT_WIDTH >= ACC_W) begin : g_wide
      // Every product fits, so only the extension kind matters.
      always_comb begin
        if (signed_i) begin
          f_next_o = OUT_WIDTH'($signed(product_i));
        end else begin
          f_next_o = OUT_WIDTH'(product_i);
        end
        of_next_o = 1'b0;
      end
    end else begin : g_narrow
      logic [ACC_W-OUT_WIDTH:0] upper_s;
      logic                     ovf_s;
      logic [OUT_WIDTH-1:0]     sat_s;

      // upper_s spans the result MSB and all discarded bits; a signed value fits
      // only when they all equal the sign, an unsigned one when the discarded bits are zero.
      always_comb begin
        upper_s = product_i[ACC_W-1:OUT_WIDTH-1];
        if (signed_i) begin
          ovf_s = !((&upper_s) || !(|upper_s));
          if (product_i[ACC_W-1]) begin
            sat_s = {1'b1, {(OUT_WIDTH-1){1'b0}}};
          end else begin
            sat_s = {1'b0, {(OUT_WIDTH-1){1'b1}}};
          end
        end else begin
          ovf_s = |upper_s[ACC_W-OUT_WIDTH:1];
          sat_s = {OUT_WIDTH{1'b1}};
        end
        of_next_o = ovf_s;
        if (ovf_s && saturate_i) begin
          f_next_o = sat_s;
        end else begin
          f_next_o = product_i[OUT_WIDTH-1:0];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/multiplicador_constante_seq.sv
// Sequential multiply-by-constant: one FACTOR bit per cycle by shift-and-add,
// valid/ready on both sides, signed/unsigned and wrap/saturate result modes.
module multiplicador_constante_seq
  import alu_pkg::*;
#(
  parameter int WIDTH        = 6,
  parameter int OUT_WIDTH    = 9,
  parameter int FACTOR       = 5,
  parameter int FACTOR_WIDTH = 3
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [WIDTH-1:0]     A,
  input  logic [1:0]           MODE,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [OUT_WIDTH-1:0] F,
  output logic                 OF,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY
);

  localparam int ACC_W = acc_width(WIDTH, FACTOR_WIDTH);
  localparam int CNT_W = $clog2(FACTOR_WIDTH + 1);
  localparam logic [FACTOR_WIDTH-1:0] FACTOR_BITS = FACTOR_WIDTH'(FACTOR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FACTOR_WIDTH - 1);

  state_e                  state_q;
  logic [ACC_W-1:0]        a_q;
  logic [FACTOR_WIDTH-1:0] fbits_q;
  logic [1:0]              mode_q;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [OUT_WIDTH-1:0]    f_q;
  logic                    of_q;

  logic [ACC_W-1:0]        a_ext_s;
  logic [OUT_WIDTH-1:0]    f_next_s;
  logic                    of_next_s;

  // Operand extension at acceptance and the next partial sum.
  always_comb begin
    if (MODE[MODE_SIGNED]) begin
      a_ext_s = ACC_W'($signed(A));
    end else begin
      a_ext_s = ACC_W'(A);
    end
    if (fbits_q[0]) begin
      acc_d = acc_q + a_q;
    end else begin
      acc_d = acc_q;
    end
  end

  // Range check runs on acc_d so the result is ready on the final CALC edge.
  sat_overflow_chk #(
    .ACC_W    (ACC_W),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_sat_overflow_chk (
    .product_i (acc_d),
    .signed_i  (mode_q[MODE_SIGNED]),
    .saturate_i(mode_q[MODE_SAT]),
    .f_next_o  (f_next_s),
    .of_next_o (of_next_s)
  );

  // Handshake FSM, shift-and-add datapath and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      fbits_q     <= '0;
      mode_q      <= 2'b00;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      of_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (IN_VALID) begin
            a_q        <= a_ext_s;
            fbits_q    <= FACTOR_BITS;
            mode_q     <= MODE;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_CALC;
          end
        end
        S_CALC: begin
          // a_q and fbits_q shift together so bit 0 always pairs with A << cnt_q.
          acc_q   <= acc_d;
          a_q     <= a_q << 1'b1;
          fbits_q <= fbits_q >> 1'b1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            f_q         <= f_next_s;
            of_q        <= of_next_s;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign F         = f_q;
  assign OF        = of_q;

endmodule

// File: tb/tb_multiplicador_constante_seq.sv
// Randomised self-checking bench: four configurations of the unit checked
// every cycle against an arithmetic reference model.
module tb_multiplicador_constante_seq;

  localparam int OWS  [4] = '{9, 8, 9, 9};
  localparam int FACS [4] = '{5, 5, 7, 0};

  logic       CLK;
  logic       RST_N;
  logic [5:0] a_s;
  logic [1:0] mode_s;
  logic       in_valid_s  [4];
  logic       in_ready_s  [4];
  logic       out_valid_s [4];
  logic       out_ready_s [4];
  logic       of_s        [4];
  logic [8:0] f0_s, f2_s, f3_s;
  logic [7:0] f1_s;

  typedef struct {
    int         idx;
    logic [8:0] f;
    logic       of;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] last_f  [4];
  logic       last_of [4];
  int         checks   = 0;
  int         failures = 0;
  bit         started  = 1'b0;

  multiplicador_constante_seq #(.WIDTH(6), .OUT_WIDTH(9), .FACTOR(5), .FACTOR_WIDTH(3)) u0 (
    .CLK(CLK), .RST_N(RST_N), .A(a_s), .MODE(mode_s), .IN_VALID(in_valid_s[0]),
    .IN_READY(in_ready_s[0]), .F(f0_s), .OF(of_s[0]), .OUT_VALID(out_valid_s[0]),
    .OUT_READY(out_ready_s[0]));
  multiplicador_constante_seq #(.WIDTH(6), .OUT_WIDTH(8), .FACTOR(5), .FACTOR_WIDTH(3)) u1 (
    .CLK(CLK), .RST_N(RST_N), .A(a_s), .MODE(mode_s), .IN_VALID(in_valid_s[1]),
    .IN_READY(in_ready_s[1]), .F(f1_s), .OF(of_s[1]), .OUT_VALID(out_valid_s[1]),
    .OUT_READY(out_ready_s[1]));
  multiplicador_constante_seq #(.WIDTH(6), .OUT_WIDTH(9), .FACTOR(7), .FACTOR_WIDTH(3)) u2 (
    .CLK(CLK), .RST_N(RST_N), .A(a_s), .MODE(mode_s), .IN_VALID(in_valid_s[2]),
    .IN_READY(in_ready_s[2]), .F(f2_s), .OF(of_s[2]), .OUT_VALID(out_valid_s[2]),
    .OUT_READY(out_ready_s[2]));
  multiplicador_constante_seq #(.WIDTH(6), .OUT_WIDTH(9), .FACTOR(0), .FACTOR_WIDTH(3)) u3 (
    .CLK(CLK), .RST_N(RST_N), .A(a_s), .MODE(mode_s), .IN_VALID(in_valid_s[3]),
    .IN_READY(in_ready_s[3]), .F(f3_s), .OF(of_s[3]), .OUT_VALID(out_valid_s[3]),
    .OUT_READY(out_ready_s[3]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [8:0] get_f(input int idx);
    case (idx)
      0:       return f0_s;
      1:       return {1'b0, f1_s};
      2:       return f2_s;
      default: return f3_s;
    endcase
  endfunction

  // Reference: exact integer product, range test, then wrap or clamp. Returns {OF, F}.
  function automatic logic [9:0] model(input int idx, input logic [5:0] a, input logic [1:0] mode);
    int   ow, av, p, mn, mx, r;
    logic ovf;
    logic [31:0] rb;
    ow = OWS[idx];
    av = mode[0] ? int'($signed(a)) : int'(a);
    p  = av * FACS[idx];
    if (mode[0]) begin
      mn = -(1 << (ow - 1));
      mx = (1 << (ow - 1)) - 1;
    end else begin
      mn = 0;
      mx = (1 << ow) - 1;
    end
    ovf = (p < mn) || (p > mx);
    if (ovf && mode[1]) r = (p < 0) ? mn : mx;
    else                r = p;
    rb = 32'(r & ((1 << ow) - 1));
    return {ovf, rb[8:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare: a valid result must match the model and hold; otherwise F/OF keep the last value.
  initial begin
    forever begin
      @(negedge CLK);
      if (started) begin
        for (int i = 0; i < 4; i++) begin
          if (out_valid_s[i]) begin
            if (exp_q.size() == 0 || exp_q[0].idx != i) begin
              chk($sformatf("valid_without_op%0d", i), 32'(out_valid_s[i]), 32'd0);
            end else begin
              chk($sformatf("F_u%0d", i), 32'(get_f(i)), 32'(exp_q[0].f));
              chk($sformatf("OF_u%0d", i), 32'(of_s[i]), 32'(exp_q[0].of));
              chk($sformatf("ready_in_done_u%0d", i), 32'(in_ready_s[i]), 32'd0);
              if (out_ready_s[i]) begin
                last_f[i]  = exp_q[0].f;
                last_of[i] = exp_q[0].of;
                void'(exp_q.pop_front());
              end
            end
          end else begin
            chk($sformatf("F_hold_u%0d", i), 32'(get_f(i)), 32'(last_f[i]));
            chk($sformatf("OF_hold_u%0d", i), 32'(of_s[i]), 32'(last_of[i]));
          end
        end
      end
    end
  end

  task automatic run_op(input int idx, input logic [5:0] a, input logic [1:0] mode, input int bp,
                        output logic [8:0] fo, output logic ofo);
    logic [9:0] e;
    int         n;
    bit         seen;
    @(posedge CLK); #1;
    chk("in_ready_idle", 32'(in_ready_s[idx]), 32'd1);
    a_s = a;
    mode_s = mode;
    in_valid_s[idx] = 1'b1;
    out_ready_s[idx] = (bp == 0);
    @(posedge CLK); #1;
    in_valid_s[idx] = 1'b0;
    e = model(idx, a, mode);
    exp_q.push_back('{idx, e[8:0], e[9]});
    a_s = 6'($urandom);
    mode_s = 2'($urandom);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge CLK); #1;
      n++;
      seen = out_valid_s[idx];
    end
    chk("latency", 32'(n), 32'd3);
    fo = get_f(idx);
    ofo = of_s[idx];
    if (!seen) begin
      exp_q.delete();
      return;
    end
    for (int c = 0; c < bp; c++) begin
      @(posedge CLK); #1;
      in_valid_s[idx] = 1'($urandom);
      a_s = 6'($urandom);
      mode_s = 2'($urandom);
    end
    in_valid_s[idx] = 1'b0;
    out_ready_s[idx] = 1'b1;
    @(posedge CLK); #1;
    out_ready_s[idx] = 1'b0;
    chk("back_to_idle_ready", 32'(in_ready_s[idx]), 32'd1);
    chk("back_to_idle_valid", 32'(out_valid_s[idx]), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [8:0] fo;
    logic       ofo;
    int         v;
    RST_N = 1'b0;
    a_s = 6'd0;
    mode_s = 2'b00;
    for (int i = 0; i < 4; i++) begin
      in_valid_s[i] = 1'b0;
      out_ready_s[i] = 1'b0;
      last_f[i] = 9'd0;
      last_of[i] = 1'b0;
    end
    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_in_ready", 32'(in_ready_s[i]), 32'd1);
      chk("rst_out_valid", 32'(out_valid_s[i]), 32'd0);
      chk("rst_F", 32'(get_f(i)), 32'd0);
      chk("rst_OF", 32'(of_s[i]), 32'd0);
    end
    RST_N = 1'b1;
    started = 1'b1;

    run_op(0, 6'h3A, 2'b01, 0, fo, ofo);
    chk("lit_signed_m6", 32'(fo), 32'h1E2);
    chk("lit_signed_m6_of", 32'(ofo), 32'd0);
    run_op(0, 6'd63, 2'b00, 1, fo, ofo);
    chk("lit_unsigned_63", 32'(fo), 32'h13B);
    chk("lit_unsigned_63_of", 32'(ofo), 32'd0);

    run_op(1, 6'd31, 2'b01, 0, fo, ofo);
    chk("lit_ow8_wrap", 32'(fo), 32'h9B);
    chk("lit_ow8_wrap_of", 32'(ofo), 32'd1);
    run_op(1, 6'd31, 2'b11, 10, fo, ofo);
    chk("lit_ow8_sat_pos", 32'(fo), 32'h7F);
    chk("lit_ow8_sat_pos_of", 32'(ofo), 32'd1);
    run_op(1, 6'h20, 2'b11, 0, fo, ofo);
    chk("lit_ow8_sat_neg", 32'(fo), 32'h80);
    chk("lit_ow8_sat_neg_of", 32'(ofo), 32'd1);
    run_op(1, 6'd63, 2'b10, 2, fo, ofo);
    chk("lit_ow8_usat", 32'(fo), 32'hFF);
    chk("lit_ow8_usat_of", 32'(ofo), 32'd1);

    // Reset two edges into CALC discards the operation.
    @(posedge CLK); #1;
    a_s = 6'd9;
    mode_s = 2'b01;
    in_valid_s[0] = 1'b1;
    @(posedge CLK); #1;
    in_valid_s[0] = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    for (int i = 0; i < 4; i++) begin
      last_f[i] = 9'd0;
      last_of[i] = 1'b0;
    end
    #1;
    chk("midcalc_rst_ready", 32'(in_ready_s[0]), 32'd1);
    chk("midcalc_rst_valid", 32'(out_valid_s[0]), 32'd0);
    chk("midcalc_rst_F", 32'(get_f(0)), 32'd0);
    chk("midcalc_rst_OF", 32'(of_s[0]), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    run_op(0, 6'd3, 2'b00, 0, fo, ofo);
    chk("lit_after_rst_3", 32'(fo), 32'd15);

    for (int k = 0; k < 200; k++) begin
      logic [1:0] m;
      m = 2'($urandom);
      if (m[0]) v = int'($urandom_range(0, 39)) - 20;
      else      v = int'($urandom_range(0, 19));
      run_op(2, 6'(v), m, int'($urandom_range(0, 3)), fo, ofo);
    end

    for (int k = 0; k < 5; k++) begin
      run_op(3, 6'($urandom), 2'($urandom), int'($urandom_range(0, 2)), fo, ofo);
      chk("lit_factor0", 32'(fo), 32'd0);
      chk("lit_factor0_of", 32'(ofo), 32'd0);
    end

    for (int k = 0; k < 40; k++) begin
      run_op(0, 6'($urandom), 2'($urandom), int'($urandom_range(0, 2)), fo, ofo);
      run_op(1, 6'($urandom), 2'($urandom), int'($urandom_range(0, 2)), fo, ofo);
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
